// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared types for the JK command sequencer: command opcodes, FSM states,
// the JK stage latency and the Q-model update rule.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_SET    = 2'd2,
    OP_TOGGLE = 2'd3
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned JK_STAGE_LATENCY = 2;

  function automatic logic apply_op(input op_e op, input logic q);
    logic r;
    r = q;
    case (op)
      OP_SET:    r = 1'b1;
      OP_CLEAR:  r = 1'b0;
      OP_TOGGLE: r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_sequencer_fifo.sv
// Command FIFO for the JK sequencer: DEPTH entries (power of two), pointers
// wrap naturally, async active-low reset on control state.
module jk_cmd_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a push is still taken if the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// JK command sequencer: queues HOLD/CLEAR/SET/TOGGLE commands, drives J/K for
// a repeat count each, and tracks predicted stage Q. Optional readback
// compare against the stage Q is enabled by defining JK_READBACK_CHECK_EN.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_REPEAT,
  output logic             CMD_READY,
  output logic             J,
  output logic             K,
  output logic             BUSY,
  output logic             DONE,
  output logic             Q_MODEL
`ifdef JK_READBACK_CHECK_EN
  ,
  input  logic             Q_FB,
  output logic             MISMATCH
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             j_q, k_q, done_q, qm_q;

  logic             full, empty, push, pop;
  logic [CW-1:0]    count;
  logic [CNT_W+1:0] head;
  op_e              head_op;
  logic [CNT_W-1:0] head_rep_d;

  assign push = CMD_VALID && CMD_READY;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W + 2)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push),
    .wdata_i ({CMD_OP, CMD_REPEAT}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign head_op    = op_e'(head[CNT_W +: 2]);
  assign head_rep_d = (head[CNT_W-1:0] == '0) ? CNT_W'(1) : head[CNT_W-1:0];

  // cnt_q is 0 in IDLE, so this covers both the idle load and the gapless
  // chain from the last cycle of the running command.
  assign pop = !empty && (state_q == IDLE || cnt_q == CNT_W'(1));

  assign CMD_READY = !full;
  assign BUSY      = (state_q == RUN) || (count != '0);
  assign J         = j_q;
  assign K         = k_q;
  assign DONE      = done_q;
  assign Q_MODEL   = qm_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      qm_q    <= 1'b0;
    end else if (pop) begin
      state_q <= RUN;
      op_q    <= head_op;
      cnt_q   <= head_rep_d;
      j_q     <= head_op[1];
      k_q     <= head_op[0];
      done_q  <= (head_rep_d == CNT_W'(1));
      qm_q    <= apply_op(head_op, qm_q);
    end else if (state_q == RUN) begin
      if (cnt_q == CNT_W'(1)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        j_q     <= 1'b0;
        k_q     <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_q - 1'b1;
        qm_q   <= apply_op(op_q, qm_q);
        done_q <= (cnt_q == CNT_W'(2));
      end
    end
  end

`ifdef JK_READBACK_CHECK_EN
  logic [JK_STAGE_LATENCY-1:0] qm_dly_q;
  logic [1:0]                  arm_q;
  logic                        mismatch_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      qm_dly_q   <= '0;
      arm_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      qm_dly_q <= {qm_dly_q[JK_STAGE_LATENCY-2:0], qm_q};
      if (arm_q != 2'd2) arm_q <= arm_q + 1'b1;
      if (arm_q == 2'd2 && Q_FB != qm_dly_q[JK_STAGE_LATENCY-1]) mismatch_q <= 1'b1;
    end
  end

  assign MISMATCH = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: queue-based command model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [CNT_W-1:0] rep = '0;
  logic             ready, j, k, busy, done, qm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef JK_READBACK_CHECK_EN
  logic q_fb, mism, stg1 = 1'b0, stg2 = 1'b0, inject = 1'b0, mism_free = 1'b1;
  always @(posedge clk) begin
    stg1 <= qm;
    stg2 <= stg1;
  end
  assign q_fb = stg2 ^ inject;
`endif

  jk_cmd_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .CMD_VALID  (valid),
    .CMD_OP     (op),
    .CMD_REPEAT (rep),
    .CMD_READY  (ready),
    .J          (j),
    .K          (k),
    .BUSY       (busy),
    .DONE       (done),
    .Q_MODEL    (qm)
`ifdef JK_READBACK_CHECK_EN
    ,
    .Q_FB       (q_fb),
    .MISMATCH   (mism)
`endif
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  op;
    int unsigned rep;
  } cmd_t;

  cmd_t        mq[$];
  int unsigned m_rem = 0;
  logic [1:0]  m_op = 2'd0;
  logic        m_q = 1'b0;

  function automatic logic next_q(input logic [1:0] o, input logic q);
    if (o == 2'd2) return 1'b1;
    if (o == 2'd1) return 1'b0;
    if (o == 2'd3) return ~q;
    return q;
  endfunction

  task automatic model_step();
    cmd_t c;
    bit   acc;
    if (!rst_n) begin
      mq.delete();
      m_rem = 0;
      m_op  = 2'd0;
      m_q   = 1'b0;
    end else begin
      acc = valid && (mq.size() < DEPTH);
      if (m_rem > 1) begin
        m_rem--;
        m_q = next_q(m_op, m_q);
      end else if (mq.size() > 0) begin
        c     = mq.pop_front();
        m_op  = c.op;
        m_rem = (c.rep == 0) ? 1 : c.rep;
        m_q   = next_q(m_op, m_q);
      end else begin
        m_rem = 0;
      end
      if (acc) begin
        c.op  = op;
        c.rep = rep;
        mq.push_back(c);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("model_j",     {7'd0, j},     {7'd0, (m_rem > 0) && m_op[1]});
      chk("model_k",     {7'd0, k},     {7'd0, (m_rem > 0) && m_op[0]});
      chk("model_done",  {7'd0, done},  {7'd0, m_rem == 1});
      chk("model_qm",    {7'd0, qm},    {7'd0, m_q});
      chk("model_busy",  {7'd0, busy},  {7'd0, (m_rem > 0) || (mq.size() > 0)});
      chk("model_ready", {7'd0, ready}, {7'd0, mq.size() < DEPTH});
`ifdef JK_READBACK_CHECK_EN
      if (mism_free) chk("model_mismatch", {7'd0, mism}, 8'd0);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] o, input logic [CNT_W-1:0] r);
    bit acc;
    acc   = 1'b0;
    valid = 1'b1;
    op    = o;
    rep   = r;
    for (int n = 0; n < 400 && !acc; n++) begin
      acc = ready;
      @(negedge clk);
    end
    if (!acc) chk("send_timeout", 8'd0, 8'd1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 400 && !idle; n++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) chk("idle_timeout", 8'd0, 8'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // {J,K,DONE,Q_MODEL} at this negedge, then advance one cycle
  task automatic chk_cyc(input string name, input logic [3:0] e);
    chk(name, {4'd0, j, k, done, qm}, {4'd0, e});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held for 3 cycles, then idle
    repeat (3) @(negedge clk);
    chk("rst_ready", {7'd0, ready}, 8'd1);
    chk("rst_jkdq",  {4'd0, j, k, done, qm}, 8'd0);
    chk("rst_busy",  {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_jkdq",  {4'd0, j, k, done, qm}, 8'd0);
    chk("idle_busy",  {7'd0, busy}, 8'd0);
    chk("idle_ready", {7'd0, ready}, 8'd1);

    // single SET, repeat 1
    send(2'd2, 8'd1);
    valid = 1'b0;
    chk_cyc("set_write", 4'b0000);
    chk_cyc("set_apply", 4'b1011);
    chk_cyc("set_after", 4'b0001);
    chk("set_busy", {7'd0, busy}, 8'd0);

    // TOGGLE x3 from Q_MODEL=0
    do_reset();
    send(2'd3, 8'd3);
    valid = 1'b0;
    chk_cyc("tog_write", 4'b0000);
    chk_cyc("tog_c1",    4'b1101);
    chk_cyc("tog_c2",    4'b1100);
    chk_cyc("tog_c3",    4'b1111);
    chk_cyc("tog_after", 4'b0001);

    // back-to-back SET r2, CLEAR r1, HOLD r0
    do_reset();
    send(2'd2, 8'd2);
    send(2'd1, 8'd1);
    send(2'd0, 8'd0);
    valid = 1'b0;
    chk_cyc("b2b_set2",  4'b1011);
    chk_cyc("b2b_clr",   4'b0110);
    chk_cyc("b2b_hold",  4'b0010);
    chk_cyc("b2b_after", 4'b0000);
    chk("b2b_busy", {7'd0, busy}, 8'd0);

    // FIFO fill: first command runs, next DEPTH fill the FIFO, one more waits
    do_reset();
    send(2'd3, 8'd5);
    send(2'd2, 8'd5);
    send(2'd1, 8'd5);
    send(2'd3, 8'd5);
    send(2'd0, 8'd5);
    chk("full_ready", {7'd0, ready}, 8'd0);
    chk("full_busy",  {7'd0, busy},  8'd1);
    send(2'd2, 8'd5);
    valid = 1'b0;
    wait_idle();
    chk("full_final_qm", {7'd0, qm}, 8'd1);

    // reset in the 4th cycle of TOGGLE x10, with a SET still queued
    do_reset();
    send(2'd3, 8'd10);
    send(2'd2, 8'd3);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_jkdq", {4'd0, j, k, done, qm}, 8'b0000_1100);
    chk("mid_busy", {7'd0, busy}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_jkdq",  {4'd0, j, k, done, qm}, 8'd0);
    chk("async_busy",  {7'd0, busy}, 8'd0);
    chk("async_ready", {7'd0, ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_jk",   {6'd0, j, k}, 8'd0);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);

`ifdef JK_READBACK_CHECK_EN
    mism_free = 1'b0;
    inject = 1'b1;
    repeat (4) @(negedge clk);
    chk("mism_set", {7'd0, mism}, 8'd1);
    inject = 1'b0;
    repeat (3) @(negedge clk);
    chk("mism_sticky", {7'd0, mism}, 8'd1);
    do_reset();
    chk("mism_clear", {7'd0, mism}, 8'd0);
    mism_free = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
